mod_barrido_teclado: RTL

- Upstream stage of the keypad input path: scans a 4x4 matrix keypad, debounces presses and encodes them to a 4-bit key code.
- Presents each accepted key on a KeyData/KeyReady/KeyRead handshake to the number-entry stage, which captures on the KeyReady rising edge and pulses KeyRead.
- One key is delivered per physical press. There is no auto-repeat.

---
 rtl/kp_pkg.sv | 42 ++++
 rtl/mod_barrido_teclado_if.sv | 12 +
 rtl/kp_row_sync.sv | 25 ++
 rtl/mod_barrido_teclado.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared definitions for the keypad scan path: key codes, scan FSM states
// and the (row, column) to key-code mapping.
package kp_pkg;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_STAR = 4'hF;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } kp_state_e;

    function automatic logic [3:0] kp_encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mod_barrido_teclado_if.sv
// Key delivery handshake between the keypad scanner (master) and the
// number-entry stage (slave).
interface mod_barrido_teclado_if;

    logic [3:0] KeyData;
    logic       KeyReady;
    logic       KeyRead;

    modport master (output KeyData, output KeyReady, input KeyRead);
    modport slave  (input KeyData, input KeyReady, output KeyRead);

endinterface

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to "no row pulled low".
module kp_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_async,
    output logic [3:0] row_sync
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= row_async;
            sync_q <= meta_q;
        end
    end

    assign row_sync = sync_q;

endmodule

// File: rtl/mod_barrido_teclado.sv
// 4x4 keypad scanner: drives one column at a time, debounces press and
// release, and hands one key code per physical press to the next stage.
module mod_barrido_teclado
    import kp_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [3:0]                   Row_in,
    output logic [3:0]                   Col_out,
    output logic                         Key_down,
    mod_barrido_teclado_if.master        kbus
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    kp_state_e          state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_sel_q, row_sel_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [3:0]         key_data_q, key_data_d;
    logic               key_ready_q, key_ready_d;
    logic               key_down_q, key_down_d;
    logic [3:0]         col_out_q, col_out_d;

    logic [3:0] row;
    logic [1:0] low_row;
    logic       row_hit;

    kp_row_sync u_row_sync (
        .clk       (Clock),
        .rst       (Reset),
        .row_async (Row_in),
        .row_sync  (row)
    );

    // Lowest-indexed row pulled low wins when several keys share a column.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) low_row = 2'(i);
        end
    end

    assign row_hit = !row[row_sel_q];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_sel_d   = row_sel_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        key_data_d  = key_data_q;
        key_ready_d = key_ready_q;
        case (state_q)
            S_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row != 4'hF) begin
                        row_sel_d = low_row;
                        deb_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (!row_hit) begin
                    dwell_d = '0;
                    state_d = S_SCAN;
                end else if (deb_q == DEB_LAST) begin
                    key_data_d  = kp_encode(row_sel_q, col_q);
                    key_ready_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            S_HOLD: begin
                if (kbus.KeyRead) begin
                    key_ready_d = 1'b0;
                    deb_d       = '0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (row_hit) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    state_d = S_SCAN;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: state_d = S_SCAN;
        endcase
        key_down_d = (state_d != S_SCAN);
        col_out_d  = ~(4'b0001 << col_d);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_SCAN;
            col_q       <= 2'd0;
            row_sel_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            key_data_q  <= 4'h0;
            key_ready_q <= 1'b0;
            key_down_q  <= 1'b0;
            col_out_q   <= 4'b1110;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_sel_q   <= row_sel_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            key_data_q  <= key_data_d;
            key_ready_q <= key_ready_d;
            key_down_q  <= key_down_d;
            col_out_q   <= col_out_d;
        end
    end

    assign Col_out       = col_out_q;
    assign Key_down      = key_down_q;
    assign kbus.KeyData  = key_data_q;
    assign kbus.KeyReady = key_ready_q;

endmodule
